pw_capture_sequencer: RTL and testbench
=======================================

# pw_capture_sequencer

Capture sequencer for the front-end sniffing path, in the `fe_clk` domain between the register block and the front-end capture datapath. It owns the capture lifecycle: arm, wait for a pattern-matcher hit, apply a programmable post-trigger delay, hold capture enable for a programmed byte count, stop early on FIFO full, then report done. The register block's `O_arm`, delay and length feed this block, and its `O_capture_enable` drives the capture datapath's enable input.

## Interface
Parameters:
- `pDELAY_WIDTH`, 20: width of post-trigger delay, in `fe_clk` cycles.
- `pLEN_WIDTH`, 16: width of capture length, in bytes.

Ports:
- `fe_clk`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `I_arm`  in  1  level arm request, already synchronized to `fe_clk`.
- `I_match`  in  1  single-cycle pattern-match pulse.
- `I_delay`  in  pDELAY_WIDTH  cycles from match to capture start.
- `I_capture_len`  in  pLEN_WIDTH  bytes to capture; 0 = unlimited.
- `I_data_wr`  in  1  capture datapath wrote one byte this cycle.
- `I_fifo_full`  in  1  capture FIFO full.
- `O_capture_enable`  out  1  enable to the capture datapath.
- `O_armed`  out  1  high in ARMED state.
- `O_capturing`  out  1  high in DELAY or CAPTURE.
- `O_done`  out  1  high in DONE state.
- `O_overflow`  out  1  sticky: capture ended by FIFO full.
- `O_byte_count`  out  pLEN_WIDTH  bytes captured in current/last run.
- `O_state`  out  3  state encoding: IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4.

## Operation
- All outputs are registered. Reset (`reset_n`=0 at a clock edge) forces IDLE, all outputs 0, and the internal counters to 0, from any state.
- `arm_rise` = `I_arm` & ~`I_arm` registered one cycle earlier.
- IDLE: on `arm_rise` go to ARMED. This latches `I_delay` and `I_capture_len`, clears `O_byte_count` and `O_overflow`. Later config changes are ignored until the next `arm_rise`.
- ARMED: on `I_match`, go to CAPTURE if the latched delay is 0. Otherwise go to DELAY, with the delay counter loaded to delay-1. Matches in any other state are ignored.
- DELAY: the counter decrements each cycle. At 0, go to CAPTURE.
- CAPTURE: `O_capture_enable`=1. Each `I_data_wr` increments `O_byte_count`, saturating at all-ones.
  - With nonzero length, the `I_data_wr` that brings the count to length moves to DONE.
  - `I_fifo_full`=1 moves to DONE and sets `O_overflow`. If it coincides with the final byte, both happen: count updates, DONE, overflow set.
  - `I_fifo_full` outside CAPTURE has no effect.
- DONE: holds until `I_arm`=0, then goes to IDLE. A re-arm requires a fresh `arm_rise`.
- Abort: `I_arm`=0 in ARMED, DELAY or CAPTURE goes to IDLE next cycle. `O_byte_count` and `O_overflow` hold their values.
- Priority within a cycle: reset > abort (`I_arm`=0) > fifo full > length reached > match/delay.
- `O_byte_count` holds after DONE or IDLE until the next `arm_rise`.

## Timing
- `arm_rise` seen at edge t: ARMED (`O_armed`=1) at t+1.
- `I_match` at edge t with delay D: `O_capture_enable` rises at t+1+D. D=0 gives 1-cycle latency.
- Final `I_data_wr`, or `I_fifo_full`, at edge t: `O_capture_enable`=0 and `O_done`=1 at t+1. The capture datapath must tolerate one enable cycle after its last accepted byte.
- Abort at edge t: all status outputs except count/overflow are 0 at t+1.
- `O_state` and all flags change on the same edge, so they are mutually consistent every cycle.

## Test plan
- Reset mid-CAPTURE with count=5 → next cycle IDLE, all outputs 0, `O_byte_count`=0.
- Arm, delay=0, len=4, match at cycle 10, `I_data_wr` every cycle from 11 → enable high cycles 11-14, `O_done` at 15, count=4, overflow=0.
- Delay=3, len=2 → enable rises exactly 4 cycles after the match cycle. A second match during DELAY or CAPTURE has no effect.
- Len=100, `I_fifo_full` after 37 bytes → DONE next cycle, count=37, `O_overflow`=1. Overflow then clears on the next `arm_rise`.
- Len=0, 300 writes then `I_arm` dropped → enable high throughout, IDLE next cycle, count=300.
- `I_arm` held high through DONE → stays DONE. Drop then raise `I_arm` → new run with relatched config.

Source files
------------

// File: rtl/pw_capture_sequencer.sv
// Capture lifecycle sequencer for the front-end sniffing path (fe_clk domain).
// Arms on a rising arm request, waits for a match, delays, then gates capture until length/full/abort.
module pw_capture_sequencer #(
  parameter int pDELAY_WIDTH = 20,
  parameter int pLEN_WIDTH   = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_match,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pLEN_WIDTH-1:0]   I_capture_len,
  input  logic                    I_data_wr,
  input  logic                    I_fifo_full,
  output logic                    O_capture_enable,
  output logic                    O_armed,
  output logic                    O_capturing,
  output logic                    O_done,
  output logic                    O_overflow,
  output logic [pLEN_WIDTH-1:0]   O_byte_count,
  output logic [2:0]              O_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_arm_d;
  logic                    w_arm_rise;
  logic                    w_latch;
  logic [pDELAY_WIDTH-1:0] r_delay;
  logic [pDELAY_WIDTH-1:0] r_delay_cnt;
  logic [pDELAY_WIDTH-1:0] w_delay_cnt_next;
  logic [pLEN_WIDTH-1:0]   r_len;
  logic [pLEN_WIDTH-1:0]   r_count;
  logic [pLEN_WIDTH-1:0]   w_count_next;
  logic [pLEN_WIDTH-1:0]   w_count_inc;
  logic                    r_overflow;
  logic                    w_overflow_next;

  assign w_arm_rise  = I_arm & ~r_arm_d;
  assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;

  // Abort (arm low) outranks every other event in the active states.
  always_comb begin
    w_state_next     = r_state;
    w_delay_cnt_next = r_delay_cnt;
    w_count_next     = r_count;
    w_overflow_next  = r_overflow;
    w_latch          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arm_rise) begin
          w_state_next    = ARMED;
          w_latch         = 1'b1;
          w_count_next    = '0;
          w_overflow_next = 1'b0;
        end
      end
      ARMED: begin
        if (!I_arm) begin
          w_state_next = IDLE;
        end else if (I_match) begin
          if (r_delay == '0) begin
            w_state_next = CAPTURE;
          end else begin
            w_state_next     = DELAY;
            w_delay_cnt_next = r_delay - 1'b1;
          end
        end
      end
      DELAY: begin
        if (!I_arm) begin
          w_state_next = IDLE;
        end else if (r_delay_cnt == '0) begin
          w_state_next = CAPTURE;
        end else begin
          w_delay_cnt_next = r_delay_cnt - 1'b1;
        end
      end
      CAPTURE: begin
        if (!I_arm) begin
          w_state_next = IDLE;
        end else begin
          if (I_data_wr) begin
            w_count_next = w_count_inc;
          end
          // A full FIFO on the final byte still counts that byte.
          if (I_fifo_full) begin
            w_state_next    = DONE;
            w_overflow_next = 1'b1;
          end else if (I_data_wr && (r_len != '0) && (w_count_inc == r_len)) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!I_arm) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      r_arm_d     <= 1'b0;
      r_delay     <= '0;
      r_len       <= '0;
      r_delay_cnt <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_arm_d     <= I_arm;
      r_delay_cnt <= w_delay_cnt_next;
      r_count     <= w_count_next;
      r_overflow  <= w_overflow_next;
      if (w_latch) begin
        r_delay <= I_delay;
        r_len   <= I_capture_len;
      end
    end
  end

  // Status flags decode the next state so they switch on the same edge as O_state.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      O_state          <= 3'd0;
      O_armed          <= 1'b0;
      O_capturing      <= 1'b0;
      O_capture_enable <= 1'b0;
      O_done           <= 1'b0;
    end else begin
      O_state          <= w_state_next;
      O_armed          <= (w_state_next == ARMED);
      O_capturing      <= (w_state_next == DELAY) || (w_state_next == CAPTURE);
      O_capture_enable <= (w_state_next == CAPTURE);
      O_done           <= (w_state_next == DONE);
    end
  end

  assign O_byte_count = r_count;
  assign O_overflow   = r_overflow;

endmodule

// File: tb/tb_pw_capture_sequencer.sv
// Directed self-checking bench for pw_capture_sequencer.
module tb_pw_capture_sequencer;
  localparam int DW = 20;
  localparam int LW = 16;

  logic          fe_clk;
  logic          reset_n;
  logic          iArm;
  logic          iMatch;
  logic [DW-1:0] iDelay;
  logic [LW-1:0] iCaptureLen;
  logic          iDataWr;
  logic          iFifoFull;
  logic          oCaptureEnable;
  logic          oArmed;
  logic          oCapturing;
  logic          oDone;
  logic          oOverflow;
  logic [LW-1:0] oByteCount;
  logic [2:0]    oState;

  int testCount = 0;
  int failCount = 0;

  pw_capture_sequencer #(.pDELAY_WIDTH(DW), .pLEN_WIDTH(LW)) dut (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_arm(iArm), .I_match(iMatch),
    .I_delay(iDelay), .I_capture_len(iCaptureLen), .I_data_wr(iDataWr),
    .I_fifo_full(iFifoFull), .O_capture_enable(oCaptureEnable), .O_armed(oArmed),
    .O_capturing(oCapturing), .O_done(oDone), .O_overflow(oOverflow),
    .O_byte_count(oByteCount), .O_state(oState)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic applyStimulus();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input int st, input int en, input int cnt);
    checkOutput({tag, " state"}, 32'(oState), 32'(st));
    checkOutput({tag, " enable"}, 32'(oCaptureEnable), 32'(en));
    checkOutput({tag, " count"}, 32'(oByteCount), 32'(cnt));
  endtask

  initial begin
    reset_n = 1'b0; iArm = 0; iMatch = 0; iDelay = '0; iCaptureLen = '0;
    iDataWr = 0; iFifoFull = 0;
    applyStimulus();
    applyStimulus();
    reset_n = 1'b1;
    applyStimulus();
    checkStatus("reset", 0, 0, 0);
    checkOutput("reset overflow", 32'(oOverflow), 0);

    // Reset mid-CAPTURE with count 5
    iArm = 1; applyStimulus();
    checkOutput("t1 armed", 32'(oArmed), 1);
    iMatch = 1; applyStimulus(); iMatch = 0;
    checkStatus("t1 capture", 3, 1, 0);
    iDataWr = 1;
    for (int i = 0; i < 5; i++) applyStimulus();
    iDataWr = 0;
    checkOutput("t1 count5", 32'(oByteCount), 5);
    reset_n = 0; applyStimulus();
    checkStatus("t1 after reset", 0, 0, 0);
    checkOutput("t1 capturing", 32'(oCapturing), 0);
    checkOutput("t1 armed0", 32'(oArmed), 0);
    reset_n = 1; iArm = 0; applyStimulus();

    // delay 0, len 4
    iDelay = 0; iCaptureLen = 4; iArm = 1; applyStimulus();
    iMatch = 1; applyStimulus(); iMatch = 0;
    checkStatus("t2 start", 3, 1, 0);
    iDataWr = 1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      if (i < 4) checkOutput("t2 enable held", 32'(oCaptureEnable), 1);
    end
    iDataWr = 0;
    checkStatus("t2 done", 4, 0, 4);
    checkOutput("t2 done flag", 32'(oDone), 1);
    checkOutput("t2 overflow", 32'(oOverflow), 0);
    iArm = 0; applyStimulus();
    checkStatus("t2 idle", 0, 0, 4);

    // delay 3, len 2, extra matches ignored
    iDelay = 3; iCaptureLen = 2; iArm = 1; applyStimulus();
    iMatch = 1; applyStimulus();
    checkStatus("t3 delay0", 2, 0, 0);
    checkOutput("t3 capturing", 32'(oCapturing), 1);
    applyStimulus(); iMatch = 0;
    applyStimulus();
    checkStatus("t3 delay2", 2, 0, 0);
    applyStimulus();
    checkStatus("t3 capture", 3, 1, 0);
    iMatch = 1; iDataWr = 1; applyStimulus(); iMatch = 0;
    checkStatus("t3 byte1", 3, 1, 1);
    applyStimulus(); iDataWr = 0;
    checkStatus("t3 done", 4, 0, 2);
    iArm = 0; applyStimulus();

    // len 100, FIFO full after 37 bytes
    iDelay = 0; iCaptureLen = 100; iArm = 1; applyStimulus();
    iMatch = 1; applyStimulus(); iMatch = 0;
    iDataWr = 1;
    for (int i = 0; i < 37; i++) applyStimulus();
    iDataWr = 0; iFifoFull = 1; applyStimulus(); iFifoFull = 0;
    checkStatus("t4 full", 4, 0, 37);
    checkOutput("t4 overflow", 32'(oOverflow), 1);
    iArm = 0; applyStimulus();
    checkOutput("t4 overflow sticky", 32'(oOverflow), 1);
    iFifoFull = 1; applyStimulus(); iFifoFull = 0;
    checkStatus("t4 full in idle", 0, 0, 37);
    iCaptureLen = 0; iArm = 1; applyStimulus();
    checkOutput("t4 overflow cleared", 32'(oOverflow), 0);
    checkStatus("t4 rearm", 1, 0, 0);

    // len 0 (unlimited), 300 writes then abort
    iMatch = 1; applyStimulus(); iMatch = 0;
    iDataWr = 1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus();
      checkOutput("t5 enable", 32'(oCaptureEnable), 1);
    end
    iDataWr = 0; iArm = 0; applyStimulus();
    checkStatus("t5 abort", 0, 0, 300);
    checkOutput("t5 capturing", 32'(oCapturing), 0);

    // Arm held through DONE, then re-arm with new config
    iDelay = 0; iCaptureLen = 1; iArm = 1; applyStimulus();
    iMatch = 1; applyStimulus(); iMatch = 0;
    iDataWr = 1; applyStimulus(); iDataWr = 0;
    iDelay = 2; iCaptureLen = 3;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkStatus("t6 hold done", 4, 0, 1);
    iArm = 0; applyStimulus();
    checkOutput("t6 idle", 32'(oState), 0);
    iArm = 1; applyStimulus();
    iDelay = 5; iCaptureLen = 9;
    checkStatus("t6 rearm", 1, 0, 0);
    iMatch = 1; applyStimulus(); iMatch = 0;
    checkOutput("t6 delay", 32'(oState), 2);
    applyStimulus();
    checkOutput("t6 delay end", 32'(oState), 2);
    applyStimulus();
    checkStatus("t6 capture", 3, 1, 0);
    iDataWr = 1;
    for (int i = 0; i < 3; i++) applyStimulus();
    iDataWr = 0;
    checkStatus("t6 done", 4, 0, 3);
    iArm = 0; applyStimulus();

    // Abort during DELAY
    iDelay = 4; iArm = 1; applyStimulus();
    iMatch = 1; applyStimulus(); iMatch = 0;
    iArm = 0; applyStimulus();
    checkStatus("t7 abort delay", 0, 0, 0);
    checkOutput("t7 capturing", 32'(oCapturing), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
